// File: rtl/md_pkg.sv
// Shared market-data definitions: message bytes, tick encodings and parser states.
// The tick type/side encodings are also consumed by the L1 book.
package md_pkg;

    localparam int unsigned CNT_W_DEF = 16;

    localparam logic [7:0] TYPE_ADD  = 8'h41;
    localparam logic [7:0] TYPE_EXEC = 8'h45;
    localparam logic [7:0] SIDE_BUY  = 8'h42;
    localparam logic [7:0] SIDE_SELL = 8'h53;

    localparam int unsigned MSG_LEN  = 10;
    localparam logic [3:0]  LAST_IDX = 4'(MSG_LEN - 1);

    localparam logic TICK_ADD  = 1'b0;
    localparam logic TICK_EXEC = 1'b1;
    localparam logic TICK_BUY  = 1'b1;
    localparam logic TICK_SELL = 1'b0;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        BODY = 2'd1,
        SKIP = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_be_shift32.sv
// 32-bit big-endian byte accumulator. value is the contents as of the next edge,
// so a consumer can capture the word in the same cycle its final byte arrives.
module md_be_shift32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [31:0] value
);

    logic [31:0] acc_q;
    logic [31:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (en) begin
            acc_d = {acc_q[23:0], din};
        end
    end

    assign value = acc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/tick_decoder.sv
// Parses fixed 10-byte Add/Exec messages from a byte stream into single-cycle ticks,
// dropping and counting malformed messages.
module tick_decoder #(
    parameter int unsigned CNT_W     = md_pkg::CNT_W_DEF,
    parameter logic [7:0]  TYPE_ADD  = md_pkg::TYPE_ADD,
    parameter logic [7:0]  TYPE_EXEC = md_pkg::TYPE_EXEC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic             tick_valid,
    output logic             tick_type,
    output logic             tick_side,
    output logic [31:0]      tick_qty,
    output logic [31:0]      tick_price,
    output logic [CNT_W-1:0] msg_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    import md_pkg::*;

    md_state_e        state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic             type_q, type_d;
    logic             side_q, side_d;
    logic             bad_q, bad_d;
    logic             tick_valid_q, tick_valid_d;
    logic             tick_type_q, tick_type_d;
    logic             tick_side_q, tick_side_d;
    logic [31:0]      tick_qty_q, tick_qty_d;
    logic [31:0]      tick_price_q, tick_price_d;
    logic [CNT_W-1:0] msg_cnt_q, msg_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic        accept;
    logic        qty_en;
    logic        price_en;
    logic [31:0] qty_val;
    logic [31:0] price_val;

    // The decoder never stalls; ready only drops while held in reset.
    assign s_ready  = ~rst;
    assign accept   = s_valid & s_ready;
    assign qty_en   = accept && (state_q == BODY) && (idx_q >= 4'd2) && (idx_q <= 4'd5);
    assign price_en = accept && (state_q == BODY) && (idx_q >= 4'd6) && (idx_q <= LAST_IDX);

    md_be_shift32 u_qty (
        .clk   (clk),
        .rst   (rst),
        .en    (qty_en),
        .din   (s_data),
        .value (qty_val)
    );

    md_be_shift32 u_price (
        .clk   (clk),
        .rst   (rst),
        .en    (price_en),
        .din   (s_data),
        .value (price_val)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        type_d       = type_q;
        side_d       = side_q;
        bad_d        = bad_q;
        tick_valid_d = 1'b0;
        tick_type_d  = tick_type_q;
        tick_side_d  = tick_side_q;
        tick_qty_d   = tick_qty_q;
        tick_price_d = tick_price_q;
        msg_cnt_d    = msg_cnt_q;
        err_cnt_d    = err_cnt_q;

        if (accept) begin
            unique case (state_q)
                HDR: begin
                    if (s_last) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end else if ((s_data == TYPE_ADD) || (s_data == TYPE_EXEC)) begin
                        type_d  = (s_data == TYPE_EXEC) ? TICK_EXEC : TICK_ADD;
                        bad_d   = 1'b0;
                        idx_d   = 4'd1;
                        state_d = BODY;
                    end else begin
                        state_d = SKIP;
                    end
                end
                BODY: begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd1) begin
                        side_d = (s_data == SIDE_BUY) ? TICK_BUY : TICK_SELL;
                        if ((s_data != SIDE_BUY) && (s_data != SIDE_SELL)) begin
                            bad_d = 1'b1;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 4'd0;
                        state_d = HDR;
                        if (!s_last) begin
                            state_d = SKIP;
                        end else if (bad_q) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end else begin
                            tick_valid_d = 1'b1;
                            tick_type_d  = type_q;
                            tick_side_d  = side_q;
                            tick_qty_d   = qty_val;
                            tick_price_d = price_val;
                            msg_cnt_d    = msg_cnt_q + CNT_W'(1);
                        end
                    end else if (s_last) begin
                        idx_d     = 4'd0;
                        state_d   = HDR;
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                end
                SKIP: begin
                    if (s_last) begin
                        idx_d     = 4'd0;
                        state_d   = HDR;
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    idx_d   = 4'd0;
                    state_d = HDR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HDR;
            idx_q        <= '0;
            type_q       <= 1'b0;
            side_q       <= 1'b0;
            bad_q        <= 1'b0;
            tick_valid_q <= 1'b0;
            tick_type_q  <= 1'b0;
            tick_side_q  <= 1'b0;
            tick_qty_q   <= '0;
            tick_price_q <= '0;
            msg_cnt_q    <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            type_q       <= type_d;
            side_q       <= side_d;
            bad_q        <= bad_d;
            tick_valid_q <= tick_valid_d;
            tick_type_q  <= tick_type_d;
            tick_side_q  <= tick_side_d;
            tick_qty_q   <= tick_qty_d;
            tick_price_q <= tick_price_d;
            msg_cnt_q    <= msg_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign tick_valid = tick_valid_q;
    assign tick_type  = tick_type_q;
    assign tick_side  = tick_side_q;
    assign tick_qty   = tick_qty_q;
    assign tick_price = tick_price_q;
    assign msg_cnt    = msg_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: doc/tick_decoder.md
Name: tick_decoder

Overview:
- Byte-stream market-data message parser. It is the producer side of the tick interface that the L1 book consumes (tick_valid/type/side/qty/price).
- It sits between the network/UDP payload extractor and the book.
- It parses fixed 10-byte add/execute messages and emits one single-cycle tick per well-formed message.
- It drops and counts malformed messages.

Parameters:
- CNT_W, 16, width of message and error counters (wrap-around, not saturating)
- TYPE_ADD, 8'h41, message-type byte for Add ('A')
- TYPE_EXEC, 8'h45, message-type byte for Exec ('E')

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- s_valid  in  1  input byte valid
- s_data  in  8  input byte
- s_last  in  1  marks final byte of a message
- s_ready  out  1  byte accepted; a byte is accepted when s_valid && s_ready
- tick_valid  out  1  one-cycle pulse: decoded tick available
- tick_type  out  1  0 = Add, 1 = Exec
- tick_side  out  1  1 = Buy, 0 = Sell
- tick_qty  out  32  quantity
- tick_price  out  32  price
- msg_cnt  out  CNT_W  count of ticks emitted
- err_cnt  out  CNT_W  count of dropped messages

Behaviour:
- Reset: the one clock is clk; rst is asynchronous and active-high. While rst is asserted, all outputs are 0 except s_ready, which is 0. The FSM goes to HDR and the byte index clears. Reset mid-message discards the partial message; it is not counted as an error.
- s_ready: 1 in every cycle after reset deasserts. The decoder never back-pressures, and the tick output has no ready.
- Message format, byte index 0..9:
  - b0: type byte.
  - b1: side byte, 'B' (8'h42) = Buy, 'S' (8'h53) = Sell.
  - b2..b5: qty, big-endian, b2 = MSB.
  - b6..b9: price, big-endian.
- HDR state, on an accepted byte:
  - TYPE_ADD or TYPE_EXEC: latch the type bit, set idx = 1, go to BODY.
  - Unknown type: flag the message as bad and go to SKIP.
  - s_last is set on b0: drop the message, err_cnt += 1, stay in HDR. This applies even if the type byte is valid.
- BODY state, on an accepted byte at idx:
  - idx = 1: decode the side byte. Any value other than 'B'/'S' flags the message as bad, but parsing continues to length.
  - idx = 2..9: shift the byte into the qty or price shadow register.
  - s_last with idx < 9 (short message): drop, err_cnt += 1, go to HDR.
  - idx = 9 with s_last and not flagged bad: on the next clock edge, tick_valid = 1 for exactly one cycle. tick_* take the shadow values, msg_cnt += 1, go to HDR.
  - idx = 9 with s_last and flagged bad: err_cnt += 1, go to HDR, no tick.
  - idx = 9 without s_last (long message): go to SKIP.
- SKIP state: discard bytes until an accepted byte with s_last. Then err_cnt += 1 and go to HDR.
- Latency: tick_valid is asserted in the cycle after b9 is accepted. Back-to-back messages are supported: b0 of the next message may be accepted in the same cycle that tick_valid is high.
- tick_type/side/qty/price update only on a tick and hold their values otherwise. They are never disturbed by dropped messages.
- s_valid low: the FSM and idx hold, so gaps inside a message are allowed.
- Counters wrap modulo 2^CNT_W. msg_cnt and err_cnt never increment in the same cycle.

Decomposition:
- Shared package md_pkg, containing:
  - type bytes (TYPE_ADD, TYPE_EXEC) and side bytes (SIDE_BUY 8'h42, SIDE_SELL 8'h53);
  - MSG_LEN = 10;
  - tick type/side encodings, shared with the book;
  - FSM state encoding (HDR, BODY, SKIP).
- One natural sub-module: md_be_shift32, a 32-bit big-endian byte-shift accumulator with load-enable. It is instantiated twice, for qty and price.

Test Plan:
- Add/Buy: bytes 41 42 00 00 00 64 00 00 27 10, s_last on b9 -> one-cycle tick_valid with type=0, side=1, qty=100, price=10000; msg_cnt=1.
- Exec/Sell back-to-back with an Add, no idle cycle between messages -> two ticks on consecutive message ends; second tick has type=1, side=0; msg_cnt=2; err_cnt=0.
- Unknown type 8'h58 followed by 9 bytes -> no tick; err_cnt=1; tick_* unchanged from the prior tick.
- Error cases:
  - short message, s_last on b5 -> err_cnt += 1;
  - 12-byte message -> no tick, err_cnt += 1;
  - side byte 8'h00 -> no tick, err_cnt += 1;
  - a valid message immediately after each error -> decodes correctly.
- s_valid gaps of 3 cycles between every byte of an Add message -> identical tick values; tick appears 1 cycle after b9.
- Assert rst asynchronously (between edges) after b4 of a message -> outputs clear immediately. After release, a fresh full message decodes correctly with msg_cnt=1 and err_cnt=0.
